// File: rtl/dct4_zigzag_buf.sv
// dct4_zigzag_buf: ping-pong 4x4 coefficient buffer, column-wise in, zigzag-ordered out.
// Define DCT_ZZ_QUANT_SHIFT_EN to enable power-of-two quantization on the output path.
module dct4_zigzag_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [32:0] in_c0,
  input  logic [32:0] in_c1,
  input  logic [32:0] in_c2,
  input  logic [32:0] in_c3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:0] out_data,
  output logic [3:0]  out_idx,
  output logic        out_last
);
  localparam logic [63:0] ZZ = {4'd15, 4'd14, 4'd11, 4'd7, 4'd10, 4'd13, 4'd12, 4'd9,
                                4'd6, 4'd3, 4'd2, 4'd5, 4'd8, 4'd4, 4'd1, 4'd0};
  logic [32:0] mem_q [2][16];
  logic        wb_q, wb_d, rb_q, rb_d;
  logic [1:0]  full_q, full_d, wcnt_q, wcnt_d;
  logic [3:0]  zc_q, zc_d, addr;
  logic [32:0] raw;
  logic        in_fire, out_fire;
  assign in_ready  = !full_q[wb_q];
  assign out_valid = full_q[rb_q];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign addr      = ZZ[{zc_q, 2'b00} +: 4];
  assign raw       = mem_q[rb_q][addr];
  assign out_idx   = zc_q;
  assign out_last  = out_valid && (zc_q == 4'd15);
`ifdef DCT_ZZ_QUANT_SHIFT_EN
  logic [7:0] shift;
  assign shift    = {6'd0, addr[3:2]} + {6'd0, addr[1:0]};
  assign out_data = (raw[31:24] <= shift) ? '0 : {raw[32], raw[31:24] - shift, raw[23:0]};
`else
  assign out_data = raw;
`endif
  // Fill and drain target different banks, so both full-flag updates apply together.
  always_comb begin
    full_d = full_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    wcnt_d = in_fire ? wcnt_q + 2'd1 : wcnt_q;
    zc_d   = out_fire ? zc_q + 4'd1 : zc_q;
    if (in_fire && wcnt_q == 2'd3) begin
      full_d[wb_q] = 1'b1;
      wb_d         = !wb_q;
    end
    if (out_fire && zc_q == 4'd15) begin
      full_d[rb_q] = 1'b0;
      rb_d         = !rb_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= '0;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      wcnt_q <= '0;
      zc_q   <= '0;
    end else begin
      full_q <= full_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      wcnt_q <= wcnt_d;
      zc_q   <= zc_d;
    end
  end
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_q[wb_q][{2'd0, wcnt_q}] <= in_c0;
      mem_q[wb_q][{2'd1, wcnt_q}] <= in_c1;
      mem_q[wb_q][{2'd2, wcnt_q}] <= in_c2;
      mem_q[wb_q][{2'd3, wcnt_q}] <= in_c3;
    end
  end
endmodule

// File: doc/dct4_zigzag_buf.md
DCT4_ZIGZAG_BUF -- requirements
Module: dct4_zigzag_buf

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  input  1  one column of a 4x4 coefficient block present on in_c0..in_c3.
REQ-004 SHALL have ports: in_ready  output  1  block accepts a column this cycle.
REQ-005 SHALL have ports: in_c0, in_c1, in_c2, in_c3  input  33 each  row 0..3 coefficient of current column, packed {sign, exp[7:0], mant[23:0]} as produced by the 2-D DCT stage.
REQ-006 SHALL have ports: out_valid  output  1  out_data holds a valid coefficient.
REQ-007 SHALL have ports: out_ready  input  1  consumer accepts out_data this cycle.
REQ-008 SHALL have ports: out_data  output  33  coefficient in zigzag order, same packing as inputs.
REQ-009 SHALL have ports: out_idx  output  4  zigzag position 0..15 of out_data.
REQ-010 SHALL have ports: out_last  output  1  high with out_valid when out_idx = 15.

Function
REQ-011 SHALL hold two 16x33 storage banks (ping-pong), a write-bank pointer wb, a read-bank pointer rb and per-bank full flags full[1:0].
REQ-012 in_ready SHALL equal !full[wb]; a column is accepted when in_valid && in_ready.
REQ-013 SHALL track accepted columns of the current block with 2-bit counter wcnt = k. The k-th accepted column SHALL store in_cR at element (row R, col k), address R*4+k.
REQ-014 On acceptance with wcnt = 3: full[wb] SHALL set, wb SHALL toggle and wcnt SHALL wrap to 0.
REQ-015 out_valid SHALL equal full[rb]. out_data SHALL be read from bank rb at the address selected by 4-bit zigzag counter zc.
REQ-016 Zigzag address for zc 0..15 SHALL be: 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
REQ-017 out_idx SHALL equal zc. On out_valid && out_ready, zc SHALL increment.
REQ-018 On handshake with zc = 15: full[rb] SHALL clear, rb SHALL toggle and zc SHALL wrap to 0.
REQ-019 out_data, out_idx and out_last SHALL stay stable while out_valid && !out_ready.
REQ-020 Latency: out_valid SHALL rise the cycle after the 4th column of a block is accepted, if rb points to that bank.
REQ-021 A set of full[wb] and a clear of full[rb] in the same cycle SHALL both take effect. They always target different banks.
REQ-022 With both banks full, in_ready SHALL be 0 until the read bank drains. No column SHALL be lost or overwritten.
REQ-023 Sustained rate: 1 coefficient per cycle out. The input stalls 12 of every 16 cycles when out_ready is held high.

Reset
REQ-024 reset SHALL clear wb, rb, wcnt, zc and full[1:0]. After reset, in_ready = 1, out_valid = 0, out_last = 0, out_idx = 0.
REQ-025 Bank contents SHALL NOT need clearing. out_data is don't-care while out_valid = 0.
REQ-026 Reset mid-block SHALL discard partial and buffered blocks. No output SHALL follow until 4 new columns are accepted.

Configuration
REQ-027 Macro DCT_ZZ_QUANT_SHIFT_EN SHALL enable power-of-two quantization on the output path.
REQ-028 With the macro defined: for element (r,c), shift = r + c. If exp <= shift, out_data SHALL be 33'b0. Otherwise out_data SHALL be {sign, exp - shift, mant}.
REQ-029 Without the macro: out_data SHALL be the stored coefficient unmodified, and no quantization logic SHALL be synthesized.

Verification
REQ-030 After reset, apply 4 columns where in_cR on column k = {0, 8'd130, 24'(R*4+k)}, with out_ready = 1. Required response: out_data mantissas in the order 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15; out_last only on the 16th beat; out_valid rises 1 cycle after the 4th accept.
REQ-031 Hold out_ready = 0 and push 8 columns. Required response: in_ready drops after the 8th accept; the 9th column is stalled; outputs stay frozen at idx 0.
REQ-032 Toggle out_ready randomly while streaming 3 blocks. Required response: 48 coefficients, in order, none duplicated or dropped.
REQ-033 Assert reset after 2 columns, then push a new block. Required response: only the new block's 16 values appear.
REQ-034 Build with DCT_ZZ_QUANT_SHIFT_EN. Input exp = 8'd3 at (3,3) -> out_data = 0 at idx 15. Input exp = 8'd130 at (1,2) -> out_data exp = 127 at idx 7.
